// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter.
// Arbitrates req0/req1 onto a single combinational-read memory port and
// returns one response per accepted request. Each transaction is
// IDLE -> ACCESS -> RESP; an illegal request skips ACCESS, so it never
// reaches memory and is answered with err=1. When both requesters are valid,
// the grant alternates between them.
//
// Handshake: a requester drives reqN_valid and holds its payload stable until
// reqN_ready. reqN_ready is combinational and high only in IDLE for the
// granted requester; the request is accepted on the rising edge where both
// valid and ready are 1, and the payload is sampled only on that edge. The
// answer is a single-cycle reqN_rvalid pulse, with reqN_rdata and reqN_err
// qualified by it.
module dmem_arbiter #(
  parameter int MEM_BYTES = 64,
  parameter int PRIO_RST  = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [63:0] req0_addr,
  input  logic [63:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_rvalid,
  output logic [63:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [63:0] req1_addr,
  input  logic [63:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_rvalid,
  output logic [63:0] req1_rdata,
  output logic        req1_err,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Write_Data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] Read_Data,
  output logic [15:0] txn_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);
  localparam logic        PRIO_INIT = (PRIO_RST != 0);

  state_t      state_q;
  logic        prio_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;
  logic        mem_we_q;
  logic        mem_re_q;
  logic        resp_valid_q;
  logic        resp_id_q;
  logic        resp_err_q;
  logic [63:0] resp_data_q;
  logic [15:0] txn_cnt_q;

  logic        any_valid;
  logic        grant_id;
  logic        accept;
  logic        sel_write;
  logic [63:0] sel_addr;
  logic [63:0] sel_wdata;
  logic [64:0] addr_end;
  logic        req_illegal;

  // Grant selection, payload mux and legality check (65-bit end address, no wrap).
  always_comb begin
    any_valid   = req0_valid | req1_valid;
    grant_id    = (req0_valid && req1_valid) ? prio_q : req1_valid;
    accept      = reset_n && (state_q == IDLE) && any_valid;
    sel_write   = grant_id ? req1_write : req0_write;
    sel_addr    = grant_id ? req1_addr  : req0_addr;
    sel_wdata   = grant_id ? req1_wdata : req0_wdata;
    addr_end    = {1'b0, sel_addr} + 65'd8;
    req_illegal = (sel_addr[2:0] != 3'd0) || (addr_end > MEM_LIMIT);
  end

  // Transaction FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      prio_q       <= PRIO_INIT;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      txn_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            prio_q    <= ~grant_id;
            resp_id_q <= grant_id;
            if (req_illegal) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_data_q  <= '0;
            end else begin
              state_q     <= ACCESS;
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
              mem_we_q    <= sel_write;
              mem_re_q    <= ~sel_write;
            end
          end
        end
        ACCESS: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_data_q  <= mem_we_q ? 64'd0 : Read_Data;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
          mem_we_q     <= 1'b0;
          mem_re_q     <= 1'b0;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_data_q  <= '0;
          if (!resp_err_q && (txn_cnt_q != 16'hFFFF)) begin
            txn_cnt_q <= txn_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready  = accept && !grant_id;
  assign req1_ready  = accept &&  grant_id;

  assign req0_rvalid = resp_valid_q && !resp_id_q;
  assign req1_rvalid = resp_valid_q &&  resp_id_q;
  assign req0_err    = resp_err_q   && !resp_id_q;
  assign req1_err    = resp_err_q   &&  resp_id_q;
  assign req0_rdata  = resp_id_q ? 64'd0 : resp_data_q;
  assign req1_rdata  = resp_id_q ? resp_data_q : 64'd0;

  assign Mem_Addr    = mem_addr_q;
  assign Write_Data  = mem_wdata_q;
  assign MemWrite    = mem_we_q;
  assign MemRead     = mem_re_q;

  assign txn_count   = txn_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed steps in one initial block, a behavioural
// memory on the memory port, and a response scoreboard fed at request time.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_write, req0_ready, req0_rvalid, req0_err;
  logic [63:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_ready, req1_rvalid, req1_err;
  logic [63:0] req1_addr, req1_wdata, req1_rdata;
  logic [63:0] Mem_Addr, Write_Data, Read_Data;
  logic        MemWrite, MemRead;
  logic [15:0] txn_count;
  logic [1:0]  dbg_state;

  logic [63:0] mem   [0:7];
  logic [63:0] model [0:7];
  logic [65:0] exp_q [$];
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          exp_txn = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(64), .PRIO_RST(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data), .MemWrite(MemWrite),
    .MemRead(MemRead), .Read_Data(Read_Data),
    .txn_count(txn_count), .dbg_state(dbg_state)
  );

  // Behavioural memory: combinational read, store on the rising edge.
  assign Read_Data = mem[Mem_Addr[5:3]];
  always @(posedge clk) begin
    if (MemWrite) mem[Mem_Addr[5:3]] <= Write_Data;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rvalid pulse pops one expected {id, err, rdata}.
  always @(negedge clk) begin
    if (req0_rvalid || req1_rvalid) begin
      logic [65:0] obs;
      check("rvalid_one_hot", req0_rvalid & req1_rvalid, 0);
      obs = req1_rvalid ? {1'b1, req1_err, req1_rdata} : {1'b0, req0_err, req0_rdata};
      check("other_side_quiet",
            req1_rvalid ? {1'b0, req0_err, req0_rdata} : {1'b0, req1_err, req1_rdata}, 0);
      check("sb_expected_resp", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("sb_resp", obs, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit id, input logic v, input logic w,
                         input logic [63:0] a, input logic [63:0] d);
    if (id) begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end
  endtask

  // Issue one request, queue its expected response, return on the negedge
  // right after the handshake edge with valid dropped.
  task automatic send(input bit id, input logic w, input logic [63:0] a, input logic [63:0] d);
    logic legal;
    int   n;
    legal = (a[2:0] == 3'd0) && (a <= 64'd56);
    @(negedge clk);
    set_req(id, 1'b1, w, a, d);
    if (!legal) begin
      exp_q.push_back({id, 1'b1, 64'd0});
    end else if (w) begin
      model[a[5:3]] = d;
      exp_q.push_back({id, 1'b0, 64'd0});
      exp_txn++;
    end else begin
      exp_q.push_back({id, 1'b0, model[a[5:3]]});
      exp_txn++;
    end
    n = 0;
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 8) begin
      @(negedge clk); #1; n++;
    end
    check("ready_seen", id ? req1_ready : req0_ready, 1);
    @(negedge clk);
    set_req(id, 1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (dbg_state != 2'd0 && n < 8) begin
      @(negedge clk); n++;
    end
    check("idle_reached", dbg_state, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int cyc;
    int last_cyc;
    reset_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 64'd8, 64'd0);
    set_req(1, 1'b0, 1'b0, 64'd0, 64'd0);
    for (int i = 0; i < 8; i++) begin
      mem[i]   = 64'h1000 + 64'(i);
      model[i] = 64'h1000 + 64'(i);
    end
    mem[0] = 64'h4;  model[0] = 64'h4;
    mem[1] = 64'h40; model[1] = 64'h40;

    // Reset state, with req0 already valid.
    #2;
    check("rst_state", dbg_state, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_mem_ctl", {MemWrite, MemRead}, 0);
    check("rst_mem_addr", Mem_Addr, 0);
    check("rst_wdata", Write_Data, 0);
    check("rst_txn", txn_count, 0);
    check("rst_resp", {req0_rvalid, req1_rvalid, req0_err, req1_err}, 0);
    @(negedge clk); @(negedge clk);
    check("rst_ready_held", {req0_ready, req1_ready}, 0);

    // Single load of byte 8, accepted on the first edge after reset.
    exp_q.push_back({1'b0, 1'b0, 64'h40});
    exp_txn++;
    reset_n = 1'b1;
    #1;
    check("t0_ready0", req0_ready, 1);
    @(negedge clk);
    check("t1_state", dbg_state, 1);
    check("t1_memread", {MemRead, MemWrite}, 2'b10);
    check("t1_mem_addr", Mem_Addr, 64'd8);
    check("t1_ready_low", req0_ready, 0);
    set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    check("t2_rvalid", req0_rvalid, 1);
    check("t2_rdata", req0_rdata, 64'h40);
    check("t2_mem_idle", {MemRead, MemWrite, Mem_Addr}, 0);
    @(negedge clk);
    check("t3_rvalid_low", req0_rvalid, 0);
    check("t3_txn", txn_count, exp_txn);

    // Store then load on req1; MemWrite lasts exactly one cycle.
    send(1, 1'b1, 64'd16, 64'hDEADBEEF);
    check("st_memwrite", {MemWrite, MemRead}, 2'b10);
    check("st_addr", Mem_Addr, 64'd16);
    check("st_wdata", Write_Data, 64'hDEADBEEF);
    @(negedge clk);
    check("st_memwrite_one", MemWrite, 0);
    wait_idle();
    check("st_mem_content", mem[2], 64'hDEADBEEF);
    send(1, 1'b0, 64'd16, 64'd0);
    wait_idle();
    check("st_txn", txn_count, exp_txn);

    // Illegal requests: misaligned, past the end, wrapping, and a legal last word.
    send(0, 1'b0, 64'd4, 64'd0);
    check("ill4_state_resp", dbg_state, 2);
    check("ill4_no_mem", {MemRead, MemWrite}, 0);
    wait_idle();
    check("ill4_txn", txn_count, exp_txn);
    send(0, 1'b0, 64'd64, 64'd0);
    check("ill64_state_resp", dbg_state, 2);
    check("ill64_no_mem", {MemRead, MemWrite}, 0);
    wait_idle();
    check("ill64_txn", txn_count, exp_txn);
    send(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h55);
    check("illwrap_no_mem", {MemRead, MemWrite}, 0);
    wait_idle();
    send(1, 1'b0, 64'd57, 64'd0);
    wait_idle();
    send(0, 1'b0, 64'd56, 64'd0);
    check("last_word_read", MemRead, 1);
    wait_idle();
    check("ill_txn", txn_count, exp_txn);

    // Random legal traffic (addresses 8..56, never word 0).
    for (int i = 0; i < 10; i++) begin
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           64'(8 * $urandom_range(1, 7)), {$urandom, $urandom});
      wait_idle();
    end
    check("rand_txn", txn_count, exp_txn);

    // Contention from reset: both valid, grants alternate 0,1,0,1 every 3 cycles.
    @(negedge clk);
    reset_n = 1'b0;
    exp_txn = 0;
    set_req(0, 1'b1, 1'b0, 64'd0, 64'd0);
    set_req(1, 1'b1, 1'b0, 64'd8, 64'd0);
    #1;
    check("cont_rst_ready", {req0_ready, req1_ready}, 0);
    check("cont_rst_txn", txn_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    cyc = 0;
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 6) begin
        @(negedge clk); #1; n++; cyc++;
      end
      check("cont_grant_seen", req0_ready | req1_ready, 1);
      check("cont_grant_id", {req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) check("cont_spacing", cyc - last_cyc, 3);
      last_cyc = cyc;
      exp_q.push_back({1'(k % 2), 1'b0, model[k % 2]});
      exp_txn++;
      @(negedge clk); #1; cyc++;
    end
    // Payload churn while busy must not disturb the in-flight access.
    set_req(0, 1'b0, 1'b1, 64'd40, 64'hBAD);
    set_req(1, 1'b0, 1'b1, 64'd48, 64'hBAD);
    check("cont_busy_addr", Mem_Addr, 64'd8);
    check("cont_busy_ctl", {MemRead, MemWrite}, 2'b10);
    wait_idle();
    check("cont_txn", txn_count, exp_txn);

    // Reset in the ACCESS cycle of a store to addr 0: no commit, no response.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 64'd0, 64'h99);
    #1;
    check("rs_ready", req0_ready, 1);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
    check("rs_memwrite_before", MemWrite, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rs_memwrite_drop", MemWrite, 0);
    check("rs_state", dbg_state, 0);
    @(negedge clk);
    check("rs_no_rvalid", {req0_rvalid, req1_rvalid}, 0);
    check("rs_mem0_kept", mem[0], 64'h4);
    reset_n = 1'b1;
    exp_txn = 0;
    @(negedge clk);
    check("rs_no_rvalid_after", {req0_rvalid, req1_rvalid}, 0);

    // Saturation of the transaction counter.
    @(negedge clk);
    force dut.txn_cnt_q = 16'hFFFE;
    #1;
    release dut.txn_cnt_q;
    check("sat_forced", txn_count, 16'hFFFE);
    send(0, 1'b0, 64'd0, 64'd0);
    wait_idle();
    check("sat_reach", txn_count, 16'hFFFF);
    send(1, 1'b0, 64'd8, 64'd0);
    wait_idle();
    check("sat_hold", txn_count, 16'hFFFF);
    send(0, 1'b0, 64'd24, 64'd0);
    wait_idle();
    check("sat_hold2", txn_count, 16'hFFFF);

    // Final report.
    @(negedge clk); @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
